packet_rr_arbiter: RTL
======================

PACKET_RR_ARBITER -- requirements
Module: packet_rr_arbiter

Interface
REQ-001 Parameter N SHALL default to 4: number of requesters, legal range 2..16.
REQ-002 Parameter ParamA SHALL default to 8: data width in bits, minimum 1.
REQ-003 Localparam IdW SHALL equal max(1, clog2(N)): grant index width.
REQ-004 i_clk  input  1: single clock; all state changes on its rising edge.
REQ-005 i_rst_n  input  1: reset, asynchronous, active-low.
REQ-006 i_req  input  N: per-requester beat valid; held until acked.
REQ-007 i_data  input  N x ParamA: per-requester beat payload.
REQ-008 i_last  input  N: per-requester tail marker; qualifies the same beat as i_data.
REQ-009 o_ack  output  N: per-requester beat accept, combinational, at most one bit set.
REQ-010 o_valid  output  1: registered output beat valid.
REQ-011 o_data  output  ParamA: registered output payload.
REQ-012 o_last  output  1: registered output tail marker.
REQ-013 o_grant_id  output  IdW: index of the requester currently owning the datapath.
REQ-014 i_ready  input  1: downstream accept; a beat transfers when o_valid and i_ready are both 1.

Function
REQ-015 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner locked).
REQ-016 In IDLE, with any i_req bit set, the winner SHALL be the first set bit at or after pointer ptr, searching upward with wrap N-1 -> 0, and the FSM SHALL enter BUSY with o_grant_id = winner on the next edge.
REQ-017 In IDLE, o_ack SHALL be all zero; arbitration costs exactly one cycle.
REQ-018 In BUSY, o_ack[o_grant_id] SHALL equal i_req[o_grant_id] and (!o_valid or i_ready); all other o_ack bits SHALL be 0.
REQ-019 On an acked beat, o_data/o_last SHALL load i_data/i_last of the owner and o_valid SHALL be 1 next cycle: one-cycle latency.
REQ-020 If o_valid and i_ready with no new acked beat, o_valid SHALL clear next cycle.
REQ-021 When the acked beat has i_last = 1, the FSM SHALL return to IDLE and ptr SHALL become (owner + 1) mod N on the same edge.
REQ-022 A single-beat packet (head = tail) SHALL release the grant after that one beat.
REQ-023 If the owner drops i_req mid-packet, the grant SHALL stay locked and no ack SHALL be issued until it re-asserts.
REQ-024 Requests from non-owners SHALL be ignored while BUSY, with no ack and no pointer change.
REQ-025 Arbitration in IDLE SHALL proceed while o_valid is still pending downstream; backpressure only gates o_ack.
REQ-026 When i_ready is held low, o_data/o_last SHALL stay stable while o_valid = 1.

Reset
REQ-027 On reset: FSM = IDLE, ptr = 0, o_grant_id = 0, o_valid = 0, o_last = 0, o_data = 0; o_ack SHALL be 0 while reset is active.
REQ-028 Reset asserted mid-packet SHALL discard the partial packet; arbitration restarts from ptr = 0 on the first edge after release.

Structure
REQ-029 Shared package packet_arbiter_pkg SHALL hold the state enum (IDLE, BUSY) and the index-width helper function.
REQ-030 One combinational sub-module rr_priority_pick (N, request vector, pointer -> one-hot and index, plus any-valid flag) SHALL implement the REQ-016 search.
REQ-031 All registers SHALL live in packet_rr_arbiter; target size is 150-300 lines.

Verification
REQ-032 N=4, ParamA=8, i_req=4'b0101 after reset, 3-beat packets, i_ready=1 -> grant 0 first (data 0x11,0x12,0x13 out, o_last on 0x13), then grant 2, ptr=3.
REQ-033 ptr=3, i_req=4'b1001 -> grant 3, then after its tail ptr wraps to 0 and grant 0.
REQ-034 Owner 1 sends one beat with i_last=1, data 0xA5 -> exactly one o_ack[1] pulse, o_data=0xA5 and o_last=1 one cycle later, FSM back to IDLE.
REQ-035 i_ready=0 for 5 cycles mid-packet -> o_ack all 0, o_data held, no beat lost or duplicated after i_ready returns to 1.
REQ-036 i_rst_n pulsed low during beat 2 of a 4-beat packet -> all outputs 0 immediately, ptr=0, new arbitration after release.
REQ-037 Owner drops i_req for 3 cycles mid-packet while requester 2 requests -> grant stays with owner, no o_ack[2] until the owner's tail.

Source files
------------

// File: rtl/packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : packet_arbiter_pkg
// Brief   : Shared FSM state type and grant-index width helper.
// Revision: 1.0
// ============================================================================
package packet_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Grant index width: never narrower than one bit, even for tiny N.
    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_priority_pick
// Brief   : Finds the first set request at or after a pointer, wrapping N-1 -> 0.
// Revision: 1.0
// ============================================================================
module rr_priority_pick
    import packet_arbiter_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IdW = id_width(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] ptr_i,
    output logic [N-1:0]   grant_oh_o,
    output logic [IdW-1:0] grant_idx_o,
    output logic           any_o
);

    always_comb begin : p_search
        int             pos;
        logic [IdW-1:0] cand;
        logic           found;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        pos         = 0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            pos  = (int'(ptr_i) + k) % N;
            cand = IdW'(pos);
            if (!found && req_i[cand]) begin
                found            = 1'b1;
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = cand;
            end
        end
        any_o = found;
    end

endmodule
`default_nettype wire

// File: rtl/packet_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : packet_rr_arbiter
// Brief   : Packet-locked round-robin arbiter with a registered output beat.
// Revision: 1.0
// ============================================================================
module packet_rr_arbiter
    import packet_arbiter_pkg::*;
#(
    parameter  int N      = 4,
    parameter  int ParamA = 8,
    localparam int IdW    = id_width(N)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N-1:0]               i_req,
    input  logic [N-1:0][ParamA-1:0]   i_data,
    input  logic [N-1:0]               i_last,
    output logic [N-1:0]               o_ack,
    output logic                       o_valid,
    output logic [ParamA-1:0]          o_data,
    output logic                       o_last,
    output logic [IdW-1:0]             o_grant_id,
    input  logic                       i_ready
);

    arb_state_e          state_q, state_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic [N-1:0]        owner_oh_q, owner_oh_d;
    logic                valid_q, valid_d;
    logic [ParamA-1:0]   data_q, data_d;
    logic                last_q, last_d;

    logic [N-1:0]        pick_oh;
    logic [IdW-1:0]      pick_idx;
    logic                pick_any;
    logic                ack_en;
    logic [IdW-1:0]      ptr_next;

    rr_priority_pick #(
        .N (N)
    ) u_pick (
        .req_i       (i_req),
        .ptr_i       (ptr_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .any_o       (pick_any)
    );

    // Output stage is free when empty or draining this cycle.
    assign ack_en   = (state_q == BUSY) && i_req[grant_q] && (!valid_q || i_ready);
    assign o_ack    = ack_en ? owner_oh_q : '0;
    assign ptr_next = (grant_q == IdW'(N - 1)) ? '0 : grant_q + IdW'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        owner_oh_d = owner_oh_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;

        if (ack_en) begin
            valid_d = 1'b1;
            data_d  = i_data[grant_q];
            last_d  = i_last[grant_q];
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = BUSY;
                    grant_d    = pick_idx;
                    owner_oh_d = pick_oh;
                end
            end
            BUSY: begin
                if (ack_en && i_last[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            owner_oh_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            owner_oh_q <= owner_oh_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_last     = last_q;
    assign o_grant_id = grant_q;

endmodule
`default_nettype wire
